// File: rtl/cache_assoc_wb_if.sv
// Processor load/store port and backing-memory port of the set-associative write-back cache.
// The master modport is the environment side; the slave modport is the cache itself.
interface cache_assoc_wb_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_hit, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back cache, one word per line, age-based LRU,
// dirty-victim write-back, read-miss fill over req/ack, saturating hit/miss counters.
module cache_assoc_wb #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SET_BITS = 2,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  cache_assoc_wb_if.slave  bus,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);
  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned TAG_W = ADDR_W - SET_BITS;
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef logic [WAY_W-1:0] way_t;
  typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;
  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StResp} state_e;

  state_e              r_state, w_state_nxt;
  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     r_dirty [SETS];
  ages_t               r_age   [SETS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]   r_data  [SETS][WAYS];
  logic                r_we, r_hit, r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_addr, r_mem_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata, r_mem_wdata;
  way_t                r_victim;
  logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

  logic [SET_BITS-1:0] w_set;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit, w_inv_found, w_vic_dirty, w_ack;
  way_t                w_hit_way, w_victim;
  logic                w_wr_en, w_wr_dirty, w_clr_dirty, w_touch_en;
  way_t                w_wr_way, w_touch_way;
  logic [DATA_W-1:0]   w_wr_data;

  // Touched way becomes age 0; every way younger than it ages by one.
  function automatic ages_t lru_touch(ages_t ages, way_t k);
    ages_t res;
    res = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (way_t'(w) == k)        res[w] = '0;
      else if (ages[w] < ages[k]) res[w] = ages[w] + 1'b1;
    end
    return res;
  endfunction

  assign w_set = r_addr[SET_BITS-1:0];
  assign w_tag = r_addr[ADDR_W-1:SET_BITS];
  assign w_ack = r_mem_req & bus.mem_ack;

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_victim    = '0;
    w_inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_t'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!w_inv_found && !r_valid[w_set][w]) begin
        w_victim    = way_t'(w);
        w_inv_found = 1'b1;
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_set][w] == way_t'(WAYS - 1)) w_victim = way_t'(w);
      end
    end
  end

  assign w_vic_dirty = r_valid[w_set][w_victim] & r_dirty[w_set][w_victim];

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_wr_way    = w_victim;
    w_wr_data   = r_wdata;
    w_wr_dirty  = 1'b1;
    w_clr_dirty = 1'b0;
    w_touch_en  = 1'b0;
    w_touch_way = w_victim;
    unique case (r_state)
      StIdle: if (bus.req_valid) w_state_nxt = StLookup;
      StLookup: begin
        if (w_hit) begin
          w_touch_en  = 1'b1;
          w_touch_way = w_hit_way;
          w_wr_en     = r_we;
          w_wr_way    = w_hit_way;
          w_state_nxt = StResp;
        end else if (w_vic_dirty) begin
          w_state_nxt = StWriteback;
        end else if (r_we) begin
          w_wr_en     = 1'b1;
          w_touch_en  = 1'b1;
          w_state_nxt = StResp;
        end else begin
          w_state_nxt = StFill;
        end
      end
      StWriteback: if (w_ack) begin
        w_wr_way    = r_victim;
        w_touch_way = r_victim;
        if (r_we) begin
          w_wr_en     = 1'b1;
          w_touch_en  = 1'b1;
          w_state_nxt = StResp;
        end else begin
          w_clr_dirty = 1'b1;
          w_state_nxt = StFill;
        end
      end
      StFill: if (w_ack) begin
        w_wr_en     = 1'b1;
        w_wr_way    = r_victim;
        w_wr_data   = bus.mem_rdata;
        w_wr_dirty  = 1'b0;
        w_touch_en  = 1'b1;
        w_touch_way = r_victim;
        w_state_nxt = StResp;
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= way_t'(w);
      end
    end else begin
      if (w_clr_dirty) r_dirty[w_set][r_victim] <= 1'b0;
      if (w_wr_en) begin
        r_valid[w_set][w_wr_way] <= 1'b1;
        r_dirty[w_set][w_wr_way] <= w_wr_dirty;
      end
      if (w_touch_en) r_age[w_set] <= lru_touch(r_age[w_set], w_touch_way);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_tag[w_set][w_wr_way]  <= w_tag;
      r_data[w_set][w_wr_way] <= w_wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we <= 1'b0;  r_addr <= '0;  r_wdata <= '0;  r_victim <= '0;
      r_hit <= 1'b0; r_rdata <= '0;
      r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_mem_addr <= '0; r_mem_wdata <= '0;
      r_hit_cnt <= '0;   r_miss_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (bus.req_valid) begin
          r_we    <= bus.req_we;
          r_addr  <= bus.req_addr;
          r_wdata <= bus.req_wdata;
        end
        StLookup: begin
          r_hit    <= w_hit;
          r_victim <= w_victim;
          if (w_hit) begin
            r_rdata <= r_we ? r_wdata : r_data[w_set][w_hit_way];
            if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + 1'b1;
          end else begin
            if (r_miss_cnt != {CNT_W{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (w_vic_dirty) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_tag[w_set][w_victim], w_set};
              r_mem_wdata <= r_data[w_set][w_victim];
            end else if (r_we) begin
              r_rdata <= r_wdata;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_addr;
            end
          end
        end
        // Fill request is staged here but only raised next cycle, leaving a gap in mem_req.
        StWriteback: if (w_ack) begin
          r_mem_req <= 1'b0;
          if (r_we) begin
            r_rdata <= r_wdata;
          end else begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_addr;
          end
        end
        StFill: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == StIdle);
  assign bus.resp_valid = (r_state == StResp);
  assign bus.resp_hit   = r_hit & (r_state == StResp);
  assign bus.resp_rdata = r_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign o_hit_cnt      = r_hit_cnt;
  assign o_miss_cnt     = r_miss_cnt;
endmodule
